// File: rtl/array_ctrl_8.sv
// ---------------------------------------------------------------------------
// array_ctrl_8 -- tile sequencer for array_8.
//
// Runs one tile per accepted start: weight load (HEIGHT rows), a column-skew
// flush, num_vec back-to-back MAC windows of MAC_CYC cycles each, and an
// output drain. The FSM produces the row-0/column-0 ("base") controls; every
// other row/column sees the same control delayed by its index through a
// shift register. Every output comes straight from a flop.
//
// Ports
//   clk       in   1        clock
//   rst_n     in   1        synchronous active-low reset
//   start     in   1        begin tile (sampled only in IDLE)
//   num_vec   in   VWIDTH   ifm vectors in the tile, latched with start
//   busy      out  1        high from the cycle after start until done
//   done      out  1        one-cycle completion pulse
//   wght_rd   out  1        weight buffer read strobe
//   ifm_rd    out  1        ifm buffer read strobe (first cycle of a window)
//   en_i      out  HEIGHT   row ifm enable, row h skewed h cycles
//   clr_i     out  HEIGHT   row accumulator clear, skewed
//   mac_done  out  HEIGHT   row end-of-window pulse, skewed
//   en_w      out  WIDTH    column weight shift enable, column w skewed w
//   clr_w     out  WIDTH    column weight clear, skewed
//   en_o      out  WIDTH    column ofm shift enable, skewed
//   clr_o     out  WIDTH    column ofm clear, skewed
//   ofm_vld   out  WIDTH    ofm[w] valid (en_o[w] delayed one cycle)
// ---------------------------------------------------------------------------
module array_ctrl_8 #(
  parameter int HEIGHT  = 8,
  parameter int WIDTH   = 8,
  parameter int MAC_CYC = 256,
  parameter int VWIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [VWIDTH-1:0] num_vec,
  output logic              busy,
  output logic              done,
  output logic              wght_rd,
  output logic              ifm_rd,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [HEIGHT-1:0] mac_done,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic [WIDTH-1:0]  ofm_vld
);

  typedef enum logic [2:0] {IDLE, WLOAD, WFLUSH, MAC, DRAIN} state_t;

  localparam int PW = $clog2(HEIGHT + WIDTH);   // phase counter (WLOAD/WFLUSH/DRAIN)
  localparam int MW = $clog2(MAC_CYC);          // window counter
  localparam int OW = $clog2(HEIGHT + 1);       // drain-burst counter

  localparam logic [PW-1:0] WLOAD_LAST  = PW'(HEIGHT - 1);
  localparam logic [PW-1:0] WFLUSH_LAST = PW'(WIDTH - 2);
  localparam logic [PW-1:0] DRAIN_LAST  = PW'(HEIGHT + WIDTH - 1);
  localparam logic [MW-1:0] WIN_LAST    = MW'(MAC_CYC - 1);
  localparam logic [OW-1:0] BURST_LAST  = OW'(HEIGHT - 1);

  state_t            state, state_nxt;
  logic [PW-1:0]     ph_cnt, ph_nxt;
  logic [MW-1:0]     win_cnt, win_nxt;
  logic [VWIDTH-1:0] vec_cnt, vec_nxt;
  logic [VWIDTH-1:0] nv_q, nv_nxt;
  logic [OW-1:0]     o_cnt, o_cnt_nxt;
  logic              o_act, o_act_nxt;

  // Base controls for the coming cycle, decoded from the next-state values
  // so that bit 0 of each skew vector is a plain register.
  logic b_en_w, b_clr_w, b_clr_o, b_en_i, b_clr_i, b_mac_done, b_en_o;
  logic b_wght_rd, b_ifm_rd, busy_d, done_d;

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ph_nxt    = ph_cnt;
    win_nxt   = win_cnt;
    vec_nxt   = vec_cnt;
    nv_nxt    = nv_q;
    o_cnt_nxt = o_cnt;
    o_act_nxt = o_act;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          nv_nxt = num_vec;
          if (num_vec == '0) begin
            done_d = 1'b1;                 // empty tile: immediate done
          end else begin
            state_nxt = WLOAD;
            ph_nxt    = '0;
          end
        end
      end
      WLOAD: begin
        if (ph_cnt == WLOAD_LAST) begin
          state_nxt = WFLUSH;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      WFLUSH: begin
        if (ph_cnt == WFLUSH_LAST) begin
          state_nxt = MAC;
          win_nxt   = '0;
          vec_nxt   = '0;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      MAC: begin
        if (win_cnt == WIN_LAST) begin
          win_nxt = '0;
          if (vec_cnt == nv_q - VWIDTH'(1)) begin
            state_nxt = DRAIN;
            ph_nxt    = '0;
          end else begin
            vec_nxt = vec_cnt + 1'b1;
          end
        end else begin
          win_nxt = win_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // Covers the last HEIGHT-beat burst plus the column skew and the
        // one-cycle ofm_vld delay.
        if (ph_cnt == DRAIN_LAST) begin
          state_nxt = IDLE;
          done_d    = 1'b1;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Output burst of HEIGHT beats starting the cycle after each window end.
    // MAC_CYC >= HEIGHT+1 guarantees a burst ends before the next one starts.
    if (state == MAC && win_cnt == WIN_LAST) begin
      o_act_nxt = 1'b1;
      o_cnt_nxt = '0;
    end else if (o_act) begin
      if (o_cnt == BURST_LAST) o_act_nxt = 1'b0;
      else                     o_cnt_nxt = o_cnt + 1'b1;
    end

    b_en_w     = (state_nxt == WLOAD);
    b_clr_w    = b_en_w && (ph_nxt == '0);
    b_clr_o    = b_clr_w;
    b_wght_rd  = b_en_w;
    b_en_i     = (state_nxt == MAC);
    b_clr_i    = b_en_i && (win_nxt == '0);
    b_ifm_rd   = b_clr_i;
    b_mac_done = b_en_i && (win_nxt == WIN_LAST);
    b_en_o     = o_act_nxt;
    busy_d     = (state_nxt != IDLE);
  end

  // NOTE: reset is synchronous and clears every flop, including the skew
  // shift registers, so an aborted tile leaves no stray enables behind.
  // NOTE: sequential state uses non-blocking assignments only, so the shift
  // registers read their pre-edge values and skew by exactly one per stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ph_cnt   <= '0;
      win_cnt  <= '0;
      vec_cnt  <= '0;
      nv_q     <= '0;
      o_cnt    <= '0;
      o_act    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wght_rd  <= 1'b0;
      ifm_rd   <= 1'b0;
      en_i     <= '0;
      clr_i    <= '0;
      mac_done <= '0;
      en_w     <= '0;
      clr_w    <= '0;
      en_o     <= '0;
      clr_o    <= '0;
      ofm_vld  <= '0;
    end else begin
      state    <= state_nxt;
      ph_cnt   <= ph_nxt;
      win_cnt  <= win_nxt;
      vec_cnt  <= vec_nxt;
      nv_q     <= nv_nxt;
      o_cnt    <= o_cnt_nxt;
      o_act    <= o_act_nxt;
      busy     <= busy_d;
      done     <= done_d;
      wght_rd  <= b_wght_rd;
      ifm_rd   <= b_ifm_rd;
      en_i     <= {en_i[HEIGHT-2:0],     b_en_i};
      clr_i    <= {clr_i[HEIGHT-2:0],    b_clr_i};
      mac_done <= {mac_done[HEIGHT-2:0], b_mac_done};
      en_w     <= {en_w[WIDTH-2:0],      b_en_w};
      clr_w    <= {clr_w[WIDTH-2:0],     b_clr_w};
      en_o     <= {en_o[WIDTH-2:0],      b_en_o};
      clr_o    <= {clr_o[WIDTH-2:0],     b_clr_o};
      ofm_vld  <= en_o;
    end
  end

endmodule

// File: tb/tb_array_ctrl_8.sv
// ---------------------------------------------------------------------------
// tb_array_ctrl_8 -- scoreboard bench for array_ctrl_8 (MAC_CYC = 16).
//
// Each issued tile pushes its expected per-cycle output waveform (derived
// from the tile timing formulas) and its expected strobe totals into queues.
// A negedge monitor compares the DUT outputs against the queue front (or
// all-zero when nothing is expected that cycle) and checks the totals on
// every done pulse.
// ---------------------------------------------------------------------------
module tb_array_ctrl_8;

  localparam int H = 8;
  localparam int W = 8;
  localparam int M = 16;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         wght_rd;
    logic         ifm_rd;
    logic [H-1:0] en_i;
    logic [H-1:0] clr_i;
    logic [H-1:0] mac_done;
    logic [W-1:0] en_w;
    logic [W-1:0] clr_w;
    logic [W-1:0] en_o;
    logic [W-1:0] clr_o;
    logic [W-1:0] ofm_vld;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  num_vec;
  logic         busy, done, wght_rd, ifm_rd;
  logic [H-1:0] en_i, clr_i, mac_done;
  logic [W-1:0] en_w, clr_w, en_o, clr_o, ofm_vld;

  array_ctrl_8 #(.HEIGHT(H), .WIDTH(W), .MAC_CYC(M), .VWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done), .wght_rd(wght_rd), .ifm_rd(ifm_rd),
    .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done),
    .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
    .ofm_vld(ofm_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   tot_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs d cycles after the start cycle of a tile of nv vectors.
  function automatic outs_t exp_at(input int d, input int nv);
    outs_t o;
    int s, e, x, y;
    o = '0;
    if (nv == 0) begin
      o.done = (d == 1);
      return o;
    end
    s = H + W;               // first MAC cycle
    e = s + nv * M - 1;      // last MAC cycle
    o.busy    = (d >= 1) && (d <= e + H + W);
    o.done    = (d == e + H + W + 1);
    o.wght_rd = (d >= 1) && (d <= H);
    o.ifm_rd  = (d >= s) && (d <= e) && ((d - s) % M == 0);
    for (int k = 0; k < H; k++) begin
      x = d - k;
      if (x >= s && x <= e) begin
        o.en_i[k]     = 1'b1;
        o.clr_i[k]    = ((x - s) % M == 0);
        o.mac_done[k] = ((x - s) % M == M - 1);
      end
    end
    for (int k = 0; k < W; k++) begin
      x = d - k;
      o.en_w[k]  = (x >= 1) && (x <= H);
      o.clr_w[k] = (x == 1);
      o.clr_o[k] = (x == 1);
      y = x - s - M;
      o.en_o[k]    = (y >= 0) && (y < nv * M) && (y % M < H);
      y = x - 1 - s - M;
      o.ofm_vld[k] = (y >= 0) && (y < nv * M) && (y % M < H);
    end
    return o;
  endfunction

  // mode 0: plain tile; 1: start pulse + num_vec change while busy;
  // 2: reset asserted in the first MAC window (tile aborted).
  task automatic run_tile(input int nv, input int mode);
    int   t, last, r;
    exp_t ent;
    t       = cyc;
    start   = 1'b1;
    num_vec = 16'(nv);
    last    = (nv == 0) ? 1 : (H + W + nv * M - 1) + H + W + 1;
    for (int d = 1; d <= last; d++) begin
      ent.cyc = t + d;
      ent.o   = exp_at(d, nv);
      exp_q.push_back(ent);
    end
    tot_q.push_back(nv);
    tick();
    start   = 1'b0;
    num_vec = 16'hABCD;
    while (cyc < t + last) begin
      start = (mode == 1 && cyc == t + 20);
      if (start) num_vec = 16'd7;
      if (mode == 2 && cyc == t + 25) begin
        r     = cyc;
        rst_n = 1'b0;
        start = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].cyc > r) void'(exp_q.pop_back());
        tot_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        return;
      end
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  // Monitor / scoreboard.
  int    cnt_wr, cnt_ifm;
  int    cnt_ofm[W];
  outs_t act, ex;
  exp_t  popped;
  int    nv_exp;

  initial begin
    cnt_wr  = 0;
    cnt_ifm = 0;
    for (int k = 0; k < W; k++) cnt_ofm[k] = 0;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      act = {busy, done, wght_rd, ifm_rd, en_i, clr_i, mac_done,
             en_w, clr_w, en_o, clr_o, ofm_vld};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        popped = exp_q.pop_front();
        ex     = popped.o;
      end else begin
        ex = '0;
      end
      check("outputs", 128'(act), 128'(ex));

      cnt_wr  += int'(wght_rd);
      cnt_ifm += int'(ifm_rd);
      for (int k = 0; k < W; k++) cnt_ofm[k] += int'(ofm_vld[k]);

      if (done === 1'b1) begin
        if (tot_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected cyc=%0d got=1 expected=0", cyc);
        end else begin
          nv_exp = tot_q.pop_front();
          check("wght_rd_total", 128'(cnt_wr), 128'((nv_exp == 0) ? 0 : H));
          check("ifm_rd_total", 128'(cnt_ifm), 128'(nv_exp));
          for (int k = 0; k < W; k++)
            check($sformatf("ofm_vld_total[%0d]", k), 128'(cnt_ofm[k]), 128'(H * nv_exp));
        end
      end

      if (done === 1'b1 || rst_n === 1'b0) begin
        cnt_wr  = 0;
        cnt_ifm = 0;
        for (int k = 0; k < W; k++) cnt_ofm[k] = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;
    num_vec = 16'd5;
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) tick();

    run_tile(1, 0);   // weight skew, first window timing
    run_tile(3, 0);   // three back-to-back windows with overlapped drain
    run_tile(0, 0);   // empty tile
    run_tile(2, 1);   // start / num_vec changes while busy are ignored
    run_tile(2, 2);   // reset mid MAC window aborts without done
    repeat (3) tick();
    run_tile(1, 0);   // clean recovery after abort
    repeat (3) tick();

    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("tot_q_drained", 128'(tot_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
